// File: rtl/ex_mem_data_stage_reg.sv
// EX->MEM data stage: per-lane source mux feeding a two-entry
// (output + skid) buffer with a valid/ready handshake.
//
// Parameters
//   DATA_WIDTH    bits per lane
//   LANES         independent data lanes, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous reset, active-low
//   sel_signals   per-lane 2-bit source select, lane i = [2i+1:2i]
//                 (00 reg file, 01 ALU, 10 MEM forward, 11 zero)
//   reg_file_data register file operands
//   alu_res       ALU results
//   fwd_data      MEM-stage forwarded values
//   in_valid      EX presents an entry
//   in_ready      stage can accept an entry (registered)
//   flush         kill every buffered entry
//   out_valid     ex_data_out holds a valid entry
//   out_ready     MEM consumes the entry this cycle
//   ex_data_out   registered stage output
module ex_mem_data_stage_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [2*LANES-1:0]          sel_signals,
   input  logic [LANES*DATA_WIDTH-1:0] reg_file_data,
   input  logic [LANES*DATA_WIDTH-1:0] alu_res,
   input  logic [LANES*DATA_WIDTH-1:0] fwd_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] ex_data_out
);

   localparam int W = LANES * DATA_WIDTH;

   logic [W-1:0] mux_data;

   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;

   logic         accept;
   logic         pop;

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < LANES; i++) begin
         unique case (sel_signals[2*i +: 2])
            2'b00:   mux_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        reg_file_data[i*DATA_WIDTH +: DATA_WIDTH];
            2'b01:   mux_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        alu_res[i*DATA_WIDTH +: DATA_WIDTH];
            2'b10:   mux_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            default: mux_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         endcase
      end
   end

   // in_ready depends only on the skid flop, which breaks the
   // combinational ready path back into EX.
   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready;
   assign pop      = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
         // Data registers keep their contents; only valids are killed.
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || pop) begin
         if (skid_valid_q) begin
            // Older skid entry leaves first. A full stage cannot
            // accept, so nothing needs to refill the skid here.
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_data_d  = mux_data;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         // Output is stalled: park the new entry in the skid.
         skid_data_d  = mux_data;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign ex_data_out = out_data_q;

endmodule

// File: tb/tb_ex_mem_data_stage_reg.sv
// Directed and random-stream bench for ex_mem_data_stage_reg.
// Two 8-bit lanes; expected values are hand-computed or queue-modelled.
module tb_ex_mem_data_stage_reg;

   localparam int DW = 8;
   localparam int L  = 2;
   localparam int W  = DW * L;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [2*L-1:0] sel_signals;
   logic [W-1:0] reg_file_data;
   logic [W-1:0] alu_res;
   logic [W-1:0] fwd_data;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ex_data_out;

   int checks   = 0;
   int failures = 0;

   ex_mem_data_stage_reg #(
      .DATA_WIDTH(DW),
      .LANES     (L)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sel_signals  (sel_signals),
      .reg_file_data(reg_file_data),
      .alu_res      (alu_res),
      .fwd_data     (fwd_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ex_data_out  (ex_data_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Independent per-lane source model.
   function automatic logic [W-1:0] model_mux(
      input logic [2*L-1:0] s, input logic [W-1:0] r,
      input logic [W-1:0] a, input logic [W-1:0] f);
      logic [W-1:0] res;
      res = '0;
      for (int i = 0; i < L; i++) begin
         if (s[2*i +: 2] == 2'd0) res[i*DW +: DW] = r[i*DW +: DW];
         if (s[2*i +: 2] == 2'd1) res[i*DW +: DW] = a[i*DW +: DW];
         if (s[2*i +: 2] == 2'd2) res[i*DW +: DW] = f[i*DW +: DW];
      end
      return res;
   endfunction

   task automatic push_reg(input logic [W-1:0] v);
      sel_signals   = '0;
      reg_file_data = v;
      in_valid      = 1'b1;
   endtask

   logic [W-1:0] q[$];
   logic [W-1:0] exp_v;
   logic [7:0]   e0 [4];
   logic [7:0]   e1 [4];
   logic [1:0]   sp0 [6];
   logic [1:0]   sp1 [6];
   bit           acc, pp;

   initial begin
      // ---- reset with random inputs ----
      reset_n       = 1'b0;
      flush         = 1'b0;
      sel_signals   = 4'($urandom);
      reg_file_data = 16'($urandom);
      alu_res       = 16'($urandom);
      fwd_data      = 16'($urandom);
      in_valid      = 1'b1;
      out_ready     = 1'($urandom);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(ex_data_out), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      step();
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_data", 32'(ex_data_out), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      // ---- lane mux sweep ----
      reg_file_data = 16'h1122;
      alu_res       = 16'h3344;
      fwd_data      = 16'h5566;
      out_ready     = 1'b1;
      e0[0] = 8'h22; e0[1] = 8'h44; e0[2] = 8'h66; e0[3] = 8'h00;
      e1[0] = 8'h11; e1[1] = 8'h33; e1[2] = 8'h55; e1[3] = 8'h00;
      sp0[0] = 2'd0; sp1[0] = 2'd0;
      sp0[1] = 2'd1; sp1[1] = 2'd1;
      sp0[2] = 2'd2; sp1[2] = 2'd2;
      sp0[3] = 2'd3; sp1[3] = 2'd3;
      sp0[4] = 2'd0; sp1[4] = 2'd3;
      sp0[5] = 2'd2; sp1[5] = 2'd1;
      for (int k = 0; k < 6; k++) begin
         sel_signals = {sp1[k], sp0[k]};
         in_valid    = 1'b1;
         step();
         chk($sformatf("mux_data_%0d", k), 32'(ex_data_out),
             32'({e1[sp1[k]], e0[sp0[k]]}));
         chk($sformatf("mux_valid_%0d", k), 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("mux_drained", 32'(out_valid), 32'd0);

      // ---- stall: A, B, then C ignored ----
      out_ready = 1'b0;
      push_reg(16'h0102);
      step();
      chk("stall_A_out", 32'(ex_data_out), 32'h0102);
      chk("stall_A_ready", 32'(in_ready), 32'd1);
      push_reg(16'h0304);
      step();
      chk("stall_B_held", 32'(ex_data_out), 32'h0102);
      chk("stall_full_ready", 32'(in_ready), 32'd0);
      push_reg(16'h0506);
      step();
      chk("stall_C_ign_out", 32'(ex_data_out), 32'h0102);
      chk("stall_C_ign_rdy", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("stall_pop_B", 32'(ex_data_out), 32'h0304);
      chk("stall_pop_B_v", 32'(out_valid), 32'd1);
      chk("stall_pop_rdy", 32'(in_ready), 32'd1);
      step();
      chk("stall_empty", 32'(out_valid), 32'd0);

      // ---- full with pop and push together ----
      out_ready = 1'b0;
      push_reg(16'h0A0A);
      step();
      push_reg(16'h0B0B);
      step();
      chk("fpp_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      push_reg(16'h0C0C);
      step();
      chk("fpp_B_first", 32'(ex_data_out), 32'h0B0B);
      chk("fpp_B_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      step();
      chk("fpp_B_hold", 32'(ex_data_out), 32'h0B0B);
      chk("fpp_C_skid", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fpp_C_out", 32'(ex_data_out), 32'h0C0C);
      step();
      chk("fpp_empty", 32'(out_valid), 32'd0);

      // ---- flush while full with an incoming entry ----
      out_ready = 1'b0;
      push_reg(16'h1111);
      step();
      push_reg(16'h2222);
      step();
      flush = 1'b1;
      push_reg(16'h3333);
      step();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      flush = 1'b0;
      in_valid = 1'b0;
      step();
      chk("flush_dropped", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      push_reg(16'h4444);
      step();
      chk("flush_next_d", 32'(ex_data_out), 32'h4444);
      chk("flush_next_v", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      step();

      // ---- async reset with two entries held ----
      out_ready = 1'b0;
      push_reg(16'h5A5A);
      step();
      push_reg(16'hA5A5);
      step();
      in_valid = 1'b0;
      chk("areset_pre_full", 32'(in_ready), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_valid", 32'(out_valid), 32'd0);
      chk("areset_ready", 32'(in_ready), 32'd1);
      chk("areset_data", 32'(ex_data_out), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("areset_after", 32'(out_valid), 32'd0);

      // ---- random streaming against a queue model ----
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() > 0)
            chk("rnd_data", 32'(ex_data_out), 32'(q[0]));
         in_valid      = 1'($urandom);
         out_ready     = ($urandom_range(0, 3) != 0);
         sel_signals   = 4'($urandom);
         reg_file_data = 16'($urandom);
         alu_res       = 16'($urandom);
         fwd_data      = 16'($urandom);
         exp_v = model_mux(sel_signals, reg_file_data, alu_res, fwd_data);
         acc = in_valid && (q.size() < 2);
         pp  = (q.size() > 0) && out_ready;
         step();
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(exp_v);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (q.size() > 0) begin
            chk("drain_data", 32'(ex_data_out), 32'(q[0]));
            void'(q.pop_front());
         end
         step();
      end
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_model", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
